instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Upstream neighbour of the multicycle control FSM. Owns PC, OldPC and the instruction register (IR).
//  On a fetch request from the control FSM it performs one valid/ready read from instruction memory,
//  latches the instruction and presents opcode[6:0] back to the FSM. Handles variable memory latency,
//  PC+4 / jump-target update, misalignment and bus-error faults.
// PARAMETERS
//  XLEN      32            datapath / address width
//  RESET_PC  32'h0000_0000 PC value after reset
// PORTS
//  clk             in   1     clock, all state updates on posedge
//  reset           in   1     synchronous, active-high
//  fetch_start     in   1     1-cycle request from control FSM (FETCH state / IRWrite)
//  pc_we           in   1     control FSM PC write (PCUpdate or Branch taken)
//  pc_next         in   XLEN  PC value written when pc_we=1
//  imem_req_valid  out  1     memory read request valid
//  imem_req_ready  in   1     memory accepts request
//  imem_req_addr   out  XLEN  read address, word aligned
//  imem_rsp_valid  in   1     read data valid, earliest 1 cycle after acceptance
//  imem_rsp_data   in   32    instruction word
//  imem_rsp_err    in   1     bus error, qualified by imem_rsp_valid
//  instr           out  32    IR contents
//  opcode          out  7     instr[6:0], combinational from IR
//  pc              out  XLEN  current PC
//  old_pc          out  XLEN  PC of the instruction held in IR
//  busy            out  1     state != IDLE
//  fetch_done      out  1     1-cycle pulse: IR valid with new instruction
//  fetch_fault     out  1     1-cycle pulse: misaligned PC or bus error
// BEHAVIOUR
//  Reset: state=IDLE, pc=old_pc=RESET_PC, instr=32'h0000_0013 (NOP), imem_req_valid=0,
//   imem_req_addr=RESET_PC, fetch_done=0, fetch_fault=0. Reset mid-transaction abandons it; a late
//   rsp_valid arriving in IDLE is ignored.
//  States: IDLE, REQ, WAIT, FAULT.
//  IDLE: fetch_start & pc[1:0]==0 -> REQ; fetch_addr <= pc.
//   fetch_start & pc[1:0]!=0 -> FAULT, no request.
//   fetch_start while busy: ignored.
//  REQ: imem_req_valid=1, imem_req_addr=fetch_addr, both held stable until imem_req_ready.
//   valid&ready -> WAIT. rsp_valid in REQ is ignored.
//  WAIT: imem_req_valid=0. On rsp_valid:
//   err=0: instr <= rsp_data, old_pc <= fetch_addr, pc <= fetch_addr+4 (mod 2^XLEN, so
//    FFFF_FFFC wraps to 0), fetch_done pulses next cycle, -> IDLE.
//   err=1: instr, old_pc, pc unchanged; fetch_fault pulses; -> IDLE.
//  FAULT: fetch_fault=1 for exactly one cycle -> IDLE. pc/instr unchanged.
//  pc_we: pc <= pc_next in any state; it has priority over the WAIT +4 update in the same cycle.
//   An in-flight request keeps fetch_addr and is unaffected.
//  Latency: ready tied 1, 1-cycle response: fetch_start@T -> req@T+1 -> rsp@T+2 -> fetch_done@T+3.
//  fetch_done and fetch_fault are never asserted together.
// STRUCTURE
//  Shared package rv32_pkg: XLEN, RESET_PC default, NOP_INSTR=32'h0000_0013,
//   opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL), fetch_state_t encoding.
//  Single module, no sub-modules. The control FSM consumes opcode, fetch_done and fetch_fault.
// TESTING
//  1 Reset, ready=1, mem[0]=0x00500093, fetch_start@T -> req addr 0@T+1, fetch_done@T+3,
//    instr=0x00500093, opcode=0x13, old_pc=0, pc=4.
//  2 ready held low 5 cycles -> valid, addr stable throughout; single acceptance; rsp 3 cycles
//    later -> exactly one fetch_done.
//  3 pc_we=1, pc_next=0x102 then fetch_start -> no req, fetch_fault 1 cycle, pc=0x102, IR unchanged.
//  4 rsp_err=1 on fetch from 0x40 -> fetch_fault pulse, pc=0x40, instr keeps old value.
//  5 pc=0xFFFF_FFFC fetch -> pc=0; pc_we (pc_next=0x80) in the rsp cycle -> pc=0x80 (pc_we wins).
//  6 reset asserted in WAIT, rsp arrives next cycle -> ignored, no fetch_done, pc=RESET_PC, instr=NOP.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the multicycle core: datapath width, reset values,
// base opcodes and the instruction-fetch state encoding.
package rv32_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_REQ   = 2'd1,
    FS_WAIT  = 2'd2,
    FS_FAULT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC, OldPC and IR; performs one valid/ready read per
// fetch request and reports completion or fault to the multicycle control FSM.
module instr_fetch_unit #(
  parameter int unsigned        XLEN     = rv32_pkg::XLEN,
  parameter logic [XLEN-1:0]    RESET_PC = XLEN'(rv32_pkg::RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_start,
  input  logic            pc_we,
  input  logic [XLEN-1:0] pc_next,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic [31:0]     instr,
  output logic [6:0]      opcode,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] old_pc,
  output logic            busy,
  output logic            fetch_done,
  output logic            fetch_fault
);
  import rv32_pkg::*;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] old_pc_q, old_pc_d;
  logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
  logic [31:0]     instr_q, instr_d;
  logic            fetch_done_q, fetch_done_d;
  logic            fetch_fault_q, fetch_fault_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    old_pc_d      = old_pc_q;
    fetch_addr_d  = fetch_addr_q;
    instr_d       = instr_q;
    fetch_done_d  = 1'b0;
    fetch_fault_d = 1'b0;

    unique case (state_q)
      FS_IDLE: begin
        if (fetch_start) begin
          if (pc_q[1:0] == 2'b00) begin
            state_d      = FS_REQ;
            fetch_addr_d = pc_q;
          end else begin
            // Pulse is registered so it lines up with the single FAULT cycle.
            state_d       = FS_FAULT;
            fetch_fault_d = 1'b1;
          end
        end
      end
      FS_REQ: begin
        if (imem_req_ready) state_d = FS_WAIT;
      end
      FS_WAIT: begin
        if (imem_rsp_valid) begin
          state_d = FS_IDLE;
          if (imem_rsp_err) begin
            fetch_fault_d = 1'b1;
          end else begin
            instr_d      = imem_rsp_data;
            old_pc_d     = fetch_addr_q;
            pc_d         = fetch_addr_q + PC_STEP;
            fetch_done_d = 1'b1;
          end
        end
      end
      FS_FAULT: begin
        state_d = FS_IDLE;
      end
      default: begin
        state_d = FS_IDLE;
      end
    endcase

    // Control-FSM write wins over the sequential +4 update; fetch_addr is untouched.
    if (pc_we) pc_d = pc_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FS_IDLE;
      pc_q          <= RESET_PC;
      old_pc_q      <= RESET_PC;
      fetch_addr_q  <= RESET_PC;
      instr_q       <= NOP_INSTR;
      fetch_done_q  <= 1'b0;
      fetch_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      old_pc_q      <= old_pc_d;
      fetch_addr_q  <= fetch_addr_d;
      instr_q       <= instr_d;
      fetch_done_q  <= fetch_done_d;
      fetch_fault_q <= fetch_fault_d;
    end
  end

  assign imem_req_valid = (state_q == FS_REQ);
  assign imem_req_addr  = fetch_addr_q;
  assign instr          = instr_q;
  assign opcode         = instr_q[6:0];
  assign pc             = pc_q;
  assign old_pc         = old_pc_q;
  assign busy           = (state_q != FS_IDLE);
  assign fetch_done     = fetch_done_q;
  assign fetch_fault    = fetch_fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        fetch_start;
  logic        pc_we;
  logic [31:0] pc_next;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [31:0] pc;
  logic [31:0] old_pc;
  logic        busy;
  logic        fetch_done;
  logic        fetch_fault;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_start    (fetch_start),
    .pc_we          (pc_we),
    .pc_next        (pc_next),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .instr          (instr),
    .opcode         (opcode),
    .pc             (pc),
    .old_pc         (old_pc),
    .busy           (busy),
    .fetch_done     (fetch_done),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic nb();
    @(negedge clk);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
  endfunction

  // Memory responder: fixed latency / forced error in directed mode, random otherwise.
  logic        rnd_mode  = 1'b0;
  int unsigned lat_fix   = 1;
  logic        err_force = 1'b0;
  logic        pend      = 1'b0;
  logic [31:0] pend_addr = '0;
  int unsigned pend_cnt  = 0;
  int unsigned accepts   = 0;

  always @(posedge clk) begin
    if (pend) begin
      if (imem_rsp_valid && pend_cnt == 0) pend <= 1'b0;
      else if (pend_cnt > 0) pend_cnt <= pend_cnt - 1;
    end
    if (imem_req_valid === 1'b1 && imem_req_ready) begin
      pend      <= 1'b1;
      pend_addr <= imem_req_addr;
      pend_cnt  <= (rnd_mode ? $urandom_range(3, 1) : lat_fix) - 1;
      accepts   <= accepts + 1;
    end
  end

  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (rnd_mode) imem_req_ready = ($urandom % 2) == 0;
      if (pend && pend_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
        imem_rsp_err   = rnd_mode ? (($urandom % 6) == 0) : err_force;
      end else if (rnd_mode && ($urandom % 8) == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = $urandom;
        imem_rsp_err   = $urandom_range(1, 0) == 1;
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        imem_rsp_err   = 1'b0;
      end
    end
  end

  // Transaction-level model: one outstanding fetch, tracked as waiting-for-accept,
  // waiting-for-response, or a one-cycle misalignment fault.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] old_pc;
    logic [31:0] instr;
    logic [31:0] addr;
    logic        reqp;
    logic        rspp;
    logic        fst;
    logic        done;
    logic        fault;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t step(input mdl_t c, input logic rst, input logic fs,
                                input logic we, input logic [31:0] nxt,
                                input logic rdy, input logic rv,
                                input logic [31:0] rd, input logic re);
    mdl_t n;
    n       = c;
    n.done  = 1'b0;
    n.fault = 1'b0;
    if (rst) begin
      n       = '0;
      n.instr = 32'h0000_0013;
      return n;
    end
    if (c.fst) begin
      n.fst = 1'b0;
    end else if (c.reqp) begin
      if (rdy) begin
        n.reqp = 1'b0;
        n.rspp = 1'b1;
      end
    end else if (c.rspp) begin
      if (rv) begin
        n.rspp = 1'b0;
        if (re) begin
          n.fault = 1'b1;
        end else begin
          n.instr  = rd;
          n.old_pc = c.addr;
          n.pc     = c.addr + 32'd4;
          n.done   = 1'b1;
        end
      end
    end else if (fs) begin
      if (c.pc[1:0] == 2'b00) begin
        n.reqp = 1'b1;
        n.addr = c.pc;
      end else begin
        n.fst   = 1'b1;
        n.fault = 1'b1;
      end
    end
    if (we) n.pc = nxt;
    return n;
  endfunction

  always @(posedge clk)
    m <= step(m, reset, fetch_start, pc_we, pc_next, imem_req_ready,
              imem_rsp_valid, imem_rsp_data, imem_rsp_err);

  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("m_pc", pc, m.pc);
      chk("m_old_pc", old_pc, m.old_pc);
      chk("m_instr", instr, m.instr);
      chk("m_opcode", 32'(opcode), 32'(m.instr[6:0]));
      chk("m_busy", 32'(busy), 32'(m.reqp | m.rspp | m.fst));
      chk("m_req_valid", 32'(imem_req_valid), 32'(m.reqp));
      if (m.reqp) chk("m_req_addr", imem_req_addr, m.addr);
      chk("m_done", 32'(fetch_done), 32'(m.done));
      chk("m_fault", 32'(fetch_fault), 32'(m.fault));
      chk("m_done_fault_excl", 32'(fetch_done & fetch_fault), 32'd0);
    end
  end

  initial begin
    int unsigned d;
    int unsigned acc0;
    reset          = 1'b1;
    fetch_start    = 1'b0;
    pc_we          = 1'b0;
    pc_next        = '0;
    imem_req_ready = 1'b1;
    nb();
    nb();

    chk("rst_pc", pc, 32'h0);
    chk("rst_old_pc", old_pc, 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_done", 32'(fetch_done), 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);

    // Basic fetch from 0 with 1-cycle memory.
    reset       = 1'b0;
    lat_fix     = 1;
    fetch_start = 1'b1;
    nb();
    fetch_start = 1'b0;
    chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t1_req_addr", imem_req_addr, 32'h0);
    nb();
    chk("t1_no_early_done", 32'(fetch_done), 32'd0);
    nb();
    chk("t1_done", 32'(fetch_done), 32'd1);
    chk("t1_instr", instr, 32'h0050_0093);
    chk("t1_opcode", 32'(opcode), 32'h13);
    chk("t1_old_pc", old_pc, 32'h0);
    chk("t1_pc", pc, 32'h4);
    nb();
    chk("t1_done_pulse", 32'(fetch_done), 32'd0);

    // Backpressure: ready low for 5 REQ cycles, 3-cycle response.
    imem_req_ready = 1'b0;
    lat_fix        = 3;
    acc0           = accepts;
    fetch_start    = 1'b1;
    nb();
    fetch_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", 32'(imem_req_valid), 32'd1);
      chk("t2_hold_addr", imem_req_addr, 32'h4);
      nb();
    end
    chk("t2_hold_valid", 32'(imem_req_valid), 32'd1);
    imem_req_ready = 1'b1;
    nb();
    imem_req_ready = 1'b0;
    chk("t2_valid_drop", 32'(imem_req_valid), 32'd0);
    d = 0;
    for (int i = 0; i < 8; i++) begin
      if (fetch_done) d++;
      nb();
    end
    chk("t2_done_count", d, 32'd1);
    chk("t2_accepts", accepts - acc0, 32'd1);
    chk("t2_pc", pc, 32'h8);
    chk("t2_old_pc", old_pc, 32'h4);
    chk("t2_instr", instr, mem_word(32'h4));

    // Misaligned PC: fault without a memory request.
    imem_req_ready = 1'b1;
    lat_fix        = 1;
    acc0           = accepts;
    pc_we          = 1'b1;
    pc_next        = 32'h102;
    nb();
    pc_we       = 1'b0;
    fetch_start = 1'b1;
    chk("t3_pc_written", pc, 32'h102);
    nb();
    fetch_start = 1'b0;
    chk("t3_fault", 32'(fetch_fault), 32'd1);
    chk("t3_no_req", 32'(imem_req_valid), 32'd0);
    chk("t3_pc", pc, 32'h102);
    chk("t3_instr", instr, mem_word(32'h4));
    nb();
    chk("t3_fault_pulse", 32'(fetch_fault), 32'd0);
    chk("t3_idle", 32'(busy), 32'd0);
    chk("t3_accepts", accepts - acc0, 32'd0);

    // Bus error on fetch from 0x40.
    pc_we   = 1'b1;
    pc_next = 32'h40;
    nb();
    pc_we       = 1'b0;
    fetch_start = 1'b1;
    err_force   = 1'b1;
    nb();
    fetch_start = 1'b0;
    chk("t4_req_addr", imem_req_addr, 32'h40);
    nb();
    nb();
    chk("t4_fault", 32'(fetch_fault), 32'd1);
    chk("t4_no_done", 32'(fetch_done), 32'd0);
    chk("t4_pc", pc, 32'h40);
    chk("t4_instr", instr, mem_word(32'h4));
    chk("t4_old_pc", old_pc, 32'h4);
    err_force = 1'b0;
    nb();
    chk("t4_fault_pulse", 32'(fetch_fault), 32'd0);

    // PC wrap, then pc_we colliding with the response cycle.
    pc_we   = 1'b1;
    pc_next = 32'hFFFF_FFFC;
    nb();
    pc_we       = 1'b0;
    fetch_start = 1'b1;
    nb();
    fetch_start = 1'b0;
    chk("t5_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    nb();
    nb();
    chk("t5_done", 32'(fetch_done), 32'd1);
    chk("t5_pc_wrap", pc, 32'h0);
    chk("t5_old_pc", old_pc, 32'hFFFF_FFFC);
    fetch_start = 1'b1;
    nb();
    fetch_start = 1'b0;
    nb();
    pc_we   = 1'b1;
    pc_next = 32'h80;
    nb();
    pc_we = 1'b0;
    chk("t5b_done", 32'(fetch_done), 32'd1);
    chk("t5b_pc_we_wins", pc, 32'h80);
    chk("t5b_old_pc", old_pc, 32'h0);
    chk("t5b_instr", instr, 32'h0050_0093);

    // Reset while waiting; the late response must be ignored.
    lat_fix     = 2;
    fetch_start = 1'b1;
    nb();
    fetch_start = 1'b0;
    nb();
    reset = 1'b1;
    nb();
    reset = 1'b0;
    chk("t6_pc_reset", pc, 32'h0);
    chk("t6_idle", 32'(busy), 32'd0);
    nb();
    chk("t6_no_done", 32'(fetch_done), 32'd0);
    chk("t6_no_fault", 32'(fetch_fault), 32'd0);
    chk("t6_instr", instr, 32'h0000_0013);
    chk("t6_pc", pc, 32'h0);
    chk("t6_old_pc", old_pc, 32'h0);

    // Randomized traffic against the model.
    rnd_mode = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      reset       = ($urandom % 150) == 0;
      fetch_start = ($urandom % 3) == 0;
      pc_we       = ($urandom % 7) == 0;
      case ($urandom % 8)
        0:       pc_next = 32'hFFFF_FFFC;
        1:       pc_next = $urandom;
        default: pc_next = 32'($urandom_range(255, 0)) << 2;
      endcase
      nb();
    end
    reset       = 1'b0;
    fetch_start = 1'b0;
    pc_we       = 1'b0;
    nb();
    nb();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
